au_inc_serial: RTL
==================

# au_inc_serial

Digit-serial incrementer that computes a WIDTH-bit `a + ci` over WIDTH/CHUNK clock cycles. Each cycle it passes one CHUNK-bit slice through an internal AU_inc_c instance and chains the slice carry-out into the next slice. It sits upstream of wide-word consumers that trade latency for area: a producer hands in an operand over a valid/ready handshake, and the block returns `z` and `co` over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, operand and result word length; must be a multiple of CHUNK.
- CHUNK, 8, slice width processed per cycle; 1 <= CHUNK <= WIDTH.
- ARCH, 0, architecture select, forwarded unchanged to the internal AU_inc_c.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept an operand.
- a  in  WIDTH  operand; sampled on the input handshake.
- ci  in  1  carry-in; sampled on the input handshake.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- z  out  WIDTH  result `(a + ci) mod 2^WIDTH`.
- co  out  1  carry-out, `(a + ci) >> WIDTH`.

## Operation
- NCHUNK = WIDTH/CHUNK. If WIDTH % CHUNK != 0 or CHUNK < 1, elaboration fails with $error.
- State registers:
  - state: IDLE, BUSY or DONE.
  - opnd: WIDTH-bit shift register.
  - res: WIDTH-bit shift register.
  - carry: 1 bit.
  - cnt: $clog2(NCHUNK+1) bits.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: opnd<=a, carry<=ci, cnt<=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle AU_inc_c (width CHUNK) receives opnd[CHUNK-1:0] and carry.
  - res <= {slice_z, res[WIDTH-1:CHUNK]} (the new slice enters at the MSB end).
  - opnd >>= CHUNK, carry <= slice_co, cnt++.
  - On the edge where cnt reaches NCHUNK-1 (the NCHUNK-th BUSY edge), go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - z=res, co=carry; both held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE.
- z is driven from res and co from carry at all times. Their values are defined only while out_valid=1, except at reset.
- Processing never terminates early: a slice with carry=0 still costs one cycle.
- in_valid while not in IDLE is ignored. The producer must hold a/ci until the handshake; the block does not queue.
- ci=0 passes a through unchanged with co=0.
- NCHUNK=1 is legal: BUSY lasts a single cycle.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, opnd=0, res=0, carry=0, cnt=0.
  - Outputs: in_ready=1, out_valid=0, z=0, co=0.
- Reset asserted mid-BUSY or in DONE discards the operation immediately. After reset release, the first accept is possible on the first rising edge.
- Latency:
  - Input handshake at edge E.
  - out_valid=1 from edge E+NCHUNK onward.
- Output handshake at edge F gives in_ready=1 after F. The next accept is possible at edge F+1.
- Minimum period between accepts: NCHUNK+2 cycles (with out_ready held high).
- No combinational path from in_valid/out_ready to any output.
- Outputs are all register-driven. in_ready and out_valid decode directly from state.

## Test plan
- Full carry ripple, WIDTH=32, CHUNK=8:
  - Stimulus: a=0xFFFFFFFF, ci=1.
  - Required: z=0x00000000, co=1; out_valid rises exactly 4 edges after the accept edge.
- Partial ripple:
  - Stimulus: a=0x000000FF, ci=1.
  - Required: z=0x00000100, co=0.
- Pass-through:
  - Stimulus: a=0x12345678, ci=0.
  - Required: z=0x12345678, co=0.
- Backpressure and ignored input:
  - Stimulus: out_ready=0 for 5 cycles in DONE, with in_valid=1 and a different a.
  - Required: out_valid, z and co stable throughout, in_ready=0, second operand not captured.
  - Then: out_ready=1 gives in_ready=1 the next cycle.
- Reset mid-operation:
  - Stimulus: rst_n low after 2 BUSY edges.
  - Required: immediately in_ready=1, out_valid=0, z=0, co=0.
  - Then: a=0x7FFFFFFF, ci=1 gives z=0x80000000, co=0.
- Random sweep:
  - Stimulus: 10000 random (a, ci) for each of (WIDTH=32, CHUNK=8), (WIDTH=32, CHUNK=32) and (WIDTH=12, CHUNK=4), with random in_valid/out_ready stalls.
  - Required: every result matches `{co, z} = a + ci`, and the result count equals the accept count.

Source files
------------

// File: rtl/au_inc_serial.sv
// au_inc_serial: digit-serial incrementer. A WIDTH-bit operand is consumed CHUNK bits per
// cycle through a small AU_inc_c slice incrementer, with the slice carry chained between
// cycles. Operands arrive and results leave over independent valid/ready handshakes.

// AU_inc_c: combinational WIDTH-bit incrementer {co, z} = a + ci.
// ARCH 0 = bit ripple, ARCH 1 = parallel-prefix AND tree, any other value = plain adder.
module AU_inc_c #(
   parameter int WIDTH = 8,
   parameter int ARCH  = 0
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic             ci_i,
   output logic [WIDTH-1:0] z_o,
   output logic             co_o
);

   if (ARCH == 0) begin : g_ripple
      // Carry into bit i+1 is a[i] & carry into bit i; the sum bit is a[i] ^ carry.
      always_comb begin
         logic c;
         c   = ci_i;
         z_o = '0;
         for (int i = 0; i < WIDTH; i++) begin
            z_o[i] = a_i[i] ^ c;
            c      = a_i[i] & c;
         end
         co_o = c;
      end
   end else if (ARCH == 1) begin : g_prefix
      localparam int NStage = (WIDTH > 1) ? $clog2(WIDTH) : 0;

      // all1[i] is set when a[i:0] is all ones (log-depth AND prefix).
      logic [WIDTH-1:0] all1;
      // lead[i] is set when every bit below i is one, so bit i flips if ci is set.
      logic [WIDTH:0]   lead;

      // Kogge-Stone style AND prefix over the operand bits.
      always_comb begin
         logic [WIDTH-1:0] nxt;
         nxt  = '0;
         all1 = a_i;
         for (int s = 0; s < NStage; s++) begin
            nxt = all1;
            for (int i = (1 << s); i < WIDTH; i++) begin
               nxt[i] = all1[i] & all1[i - (1 << s)];
            end
            all1 = nxt;
         end
      end

      assign lead = {all1, 1'b1};
      assign z_o  = a_i ^ ({WIDTH{ci_i}} & lead[WIDTH-1:0]);
      assign co_o = ci_i & lead[WIDTH];
   end else begin : g_behav
      assign {co_o, z_o} = {1'b0, a_i} + {{WIDTH{1'b0}}, ci_i};
   end

endmodule

module au_inc_serial #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int ARCH  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             co
);

   localparam int NChunk = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
   localparam int CntW   = $clog2(NChunk + 1);

   if (CHUNK < 1) begin : g_bad_chunk
      $error("au_inc_serial: CHUNK must be at least 1");
   end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("au_inc_serial: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              carry_q, carry_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic [CHUNK-1:0]  slice_z;
   logic              slice_co;
   logic [WIDTH-1:0]  res_shift;

   AU_inc_c #(
      .WIDTH (CHUNK),
      .ARCH  (ARCH)
   ) u_inc (
      .a_i  (opnd_q[CHUNK-1:0]),
      .ci_i (carry_q),
      .z_o  (slice_z),
      .co_o (slice_co)
   );

   // New slice enters at the MSB end so the first slice ends up at the LSB after NChunk shifts.
   if (CHUNK >= WIDTH) begin : g_res_whole
      assign res_shift = slice_z;
   end else begin : g_res_shift
      assign res_shift = {slice_z, res_q[WIDTH-1:CHUNK]};
   end

   // Next-state: accept in idle, one slice per busy cycle, hold the result until taken.
   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               opnd_d  = a;
               carry_d = ci;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            // No early exit on a zero carry: latency is fixed at NChunk busy cycles.
            res_d   = res_shift;
            opnd_d  = opnd_q >> CHUNK;
            carry_d = slice_co;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntW'(NChunk - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         opnd_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake outputs decode from state only; data outputs come straight from registers.
   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign z         = res_q;
   assign co        = carry_q;

endmodule
